keypad_seq_matcher: RTL and testbench
=====================================

// Module: keypad_seq_matcher
// PURPOSE
//  Parametrised keypad sequence detector: keeps a sliding window of the last SEQ_LEN accepted key digits
//  and compares it each key against NUM_PAT runtime-programmable patterns. Sits between the keypad
//  debouncer/encoder and the access-control logic. Adds a clear key, a fill-state FSM, per-pattern enables,
//  a priority hit index and an optional inter-key timeout.
// PARAMETERS
//  DIGIT_W     4     width of one key code
//  SEQ_LEN     4     digits per pattern / window depth (>=2)
//  NUM_PAT     2     number of programmable patterns (>=1)
//  CLR_KEY     4'hF  key code that clears the window instead of being shifted in
//  TIMEOUT_CYC 1000  idle cycles before partial entry is discarded (used only with KPD_TIMEOUT_EN)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  reset_n    in   1                   asynchronous active-low reset
//  key_valid  in   1                   din accepted this cycle (one cycle per key press)
//  din        in   DIGIT_W             key code
//  cfg_we     in   1                   write pattern cfg_idx
//  cfg_idx    in   $clog2(NUM_PAT)     pattern slot; out-of-range index ignored
//  cfg_pat    in   SEQ_LEN*DIGIT_W     digit k (k=0 first pressed) at [k*DIGIT_W +: DIGIT_W]
//  cfg_en     in   1                   enable bit written with the pattern
//  match_vec  out  NUM_PAT             one-cycle pulse per matching pattern
//  hit        out  1                   OR of match_vec (same cycle)
//  hit_idx    out  $clog2(NUM_PAT)     lowest matching index, valid when hit; holds last value otherwise
//  fsm_state  out  2                   IDLE=0, COLLECT=1, ARMED=2
//  timeout    out  1                   one-cycle pulse when the window is discarded on timeout
// BEHAVIOUR
//  Reset: window, fill count, all patterns and enables = 0; match_vec=0, hit=0, hit_idx=0, fsm_state=IDLE, timeout=0.
//  Accepted key (key_valid=1, din!=CLR_KEY): window shifts, newest digit in, oldest out; fill saturates at SEQ_LEN.
//  Clear key (key_valid=1, din==CLR_KEY): fill=0, window contents zeroed, no match; FSM -> IDLE.
//  FSM: IDLE (fill=0) -> COLLECT on first digit; COLLECT -> ARMED when fill reaches SEQ_LEN;
//   ARMED stays ARMED on further digits (sliding); any state -> IDLE on clear key or timeout.
//  Match: on an accepted digit, compute next window; match_vec[p] registered = en[p] & (next fill==SEQ_LEN)
//   & (next window == pat[p]). Latency: pulse in the cycle after the key_valid edge, exactly 1 cycle wide.
//  Several patterns may match at once: all bits set, hit_idx = lowest index.
//  No match evaluated on cycles without key_valid; repeated identical patterns each re-evaluate per key.
//  Config write: takes effect at the clock edge; key in the same cycle compares against the OLD pattern/enable.
//  Reset mid-entry: everything returns to reset values asynchronously; outputs clear immediately.
// CONFIGURATION
//  KPD_TIMEOUT_EN defined: idle counter counts while fill>0 and no key_valid; reset on each key or clear;
//   at TIMEOUT_CYC idle cycles window discarded (fill=0, FSM->IDLE), timeout pulses one cycle.
//   key_valid in the terminal-count cycle wins: key processed, counter restarts, no timeout.
//  KPD_TIMEOUT_EN undefined: no counter logic; timeout tied 0; partial entries kept indefinitely.
// STRUCTURE
//  Package keypad_pkg: fsm state enum (IDLE/COLLECT/ARMED), state width, default CLR_KEY constant.
//  One sub-module keypad_pat_cmp: one pattern register + enable + comparator, generated NUM_PAT times.
//  Top holds window shift register, fill counter, FSM, priority encoder, optional timeout counter.
// TESTING
//  1 program p0=0,5,3,1 en=1; keys 0,5,3,1 -> match_vec=01, hit=1, hit_idx=0 one cycle after the 4th key.
//  2 p0=0,5,3,1, p1=0,6,1,9; keys 7,0,6,1,9 -> only after 9: match_vec=10, hit_idx=1; FSM IDLE->COLLECT->ARMED.
//  3 keys 0,5,F,3,1 -> no match; FSM IDLE after F; then 0,5,3,1 -> match p0.
//  4 p0=p1=2,2,2,2 both enabled; keys 2 x5 -> match_vec=11, hit_idx=0 after 4th and 5th key.
//  5 p0 en=0 written same cycle as final key of 0,5,3,1 -> match fires; next entry 0,5,3,1 -> no match.
//  6 KPD_TIMEOUT_EN, TIMEOUT_CYC=8: keys 0,5 then 8 idle cycles -> timeout pulse, fill=0; key on cycle 8 -> no timeout; reset_n low mid-entry -> all outputs 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad sequence matcher.
// Build option: KPD_TIMEOUT_EN enables the inter-key timeout.
package keypad_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ARMED   = 2'd2
  } kpd_state_t;

  localparam logic [3:0] CLR_KEY_DEF = 4'hF;

endpackage

// File: rtl/keypad_pat_cmp.sv
// One programmable pattern slot: pattern register, enable bit and
// an equality comparator against the candidate window.
module keypad_pat_cmp #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [W-1:0] pat_in,
  input  logic         en_in,
  input  logic [W-1:0] win,
  output logic         eq
);

  logic [W-1:0] pat_q;
  logic         en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      en_q  <= 1'b0;
    end else if (we) begin
      pat_q <= pat_in;
      en_q  <= en_in;
    end
  end

  assign eq = en_q && (win == pat_q);

endmodule

// File: rtl/keypad_seq_matcher.sv
// Sliding-window keypad sequence detector with NUM_PAT patterns.
// Build option: KPD_TIMEOUT_EN adds the inter-key idle timeout.
module keypad_seq_matcher
  import keypad_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int SEQ_LEN     = 4,
  parameter int NUM_PAT     = 2,
  parameter logic [DIGIT_W-1:0] CLR_KEY = DIGIT_W'(CLR_KEY_DEF),
  parameter int TIMEOUT_CYC = 1000,
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int WIN_W = SEQ_LEN * DIGIT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] din,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [WIN_W-1:0]   cfg_pat,
  input  logic               cfg_en,
  output logic [NUM_PAT-1:0] match_vec,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [STATE_W-1:0] fsm_state,
  output logic               timeout
);

  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

  logic [WIN_W-1:0]   win_q, win_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  kpd_state_t         state_q, state_d;
  logic [NUM_PAT-1:0] eq_vec, match_d;
  logic [IDX_W-1:0]   idx_d;
  logic               is_clr, is_key, full_d, to_hit;

  assign is_clr = key_valid && (din == CLR_KEY);
  assign is_key = key_valid && (din != CLR_KEY);

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (is_clr || to_hit) begin
      win_d  = '0;
      fill_d = '0;
    end else if (is_key) begin
      // oldest digit sits at the low end, matching cfg_pat layout
      win_d = {din, win_q[WIN_W-1:DIGIT_W]};
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
    end
  end

  assign full_d = (fill_d == FULL);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      is_clr || to_hit:  state_d = IDLE;
      is_key && full_d:  state_d = ARMED;
      is_key && !full_d: state_d = COLLECT;
      default:           state_d = state_q;
    endcase
  end

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
    keypad_pat_cmp #(.W(WIN_W)) u_cmp (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (cfg_we && (cfg_idx == IDX_W'(p))),
      .pat_in  (cfg_pat),
      .en_in   (cfg_en),
      .win     (win_d),
      .eq      (eq_vec[p])
    );
  end

  always_comb begin
    match_d = (is_key && full_d) ? eq_vec : '0;
    idx_d   = hit_idx;
    for (int p = NUM_PAT - 1; p >= 0; p--) begin
      if (match_d[p]) idx_d = IDX_W'(p);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q     <= '0;
      fill_q    <= '0;
      state_q   <= IDLE;
      match_vec <= '0;
      hit_idx   <= '0;
    end else begin
      win_q     <= win_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      match_vec <= match_d;
      hit_idx   <= idx_d;
    end
  end

  assign hit       = |match_vec;
  assign fsm_state = state_q;

`ifdef KPD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_q;

  // a key in the terminal cycle suppresses the discard
  assign to_hit = (fill_q != '0) && !key_valid &&
                  (idle_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (key_valid || (fill_q == '0) || to_hit) idle_q <= '0;
      else idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_seq_matcher.sv
// Directed bench for keypad_seq_matcher (DIGIT_W=4, SEQ_LEN=4,
// NUM_PAT=2, TIMEOUT_CYC=8); timeout checks follow KPD_TIMEOUT_EN.
module tb_keypad_seq_matcher;

  logic        clk;
  logic        reset_n;
  logic        key_valid;
  logic [3:0]  din;
  logic        cfg_we;
  logic [0:0]  cfg_idx;
  logic [15:0] cfg_pat;
  logic        cfg_en;
  logic [1:0]  match_vec;
  logic        hit;
  logic [0:0]  hit_idx;
  logic [1:0]  fsm_state;
  logic        timeout;

  int n_chk  = 0;
  int n_pass = 0;

  keypad_seq_matcher #(
    .DIGIT_W(4), .SEQ_LEN(4), .NUM_PAT(2),
    .CLR_KEY(4'hF), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .key_valid(key_valid), .din(din),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pat(cfg_pat), .cfg_en(cfg_en),
    .match_vec(match_vec), .hit(hit),
    .hit_idx(hit_idx), .fsm_state(fsm_state),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] pk(input logic [3:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // all tasks start and end on a falling edge
  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    din       = d;
    @(negedge clk);
    key_valid = 1'b0;
    din       = '0;
  endtask

  task automatic cfg(input logic idx, input logic [15:0] p,
                     input logic en);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_pat = p;
    cfg_en  = en;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [1:0] mv,
                      input logic [0:0] idx, input logic [1:0] st);
    check({tag, ".match"}, 32'(match_vec), 32'(mv));
    check({tag, ".hit"},   32'(hit),       32'(|mv));
    check({tag, ".idx"},   32'(hit_idx),   32'(idx));
    check({tag, ".state"}, 32'(fsm_state), 32'(st));
  endtask

  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    din       = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_pat   = '0;
    cfg_en    = 1'b0;
    repeat (2) @(negedge clk);
    outs("rst", 2'b00, 1'b0, 2'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single pattern
    cfg(1'b0, pk(0, 5, 3, 1), 1'b1);
    press(4'h0);
    outs("t1.k0", 2'b00, 1'b0, 2'd1);
    press(4'h5);
    press(4'h3);
    outs("t1.k3", 2'b00, 1'b0, 2'd1);
    press(4'h1);
    outs("t1.k4", 2'b01, 1'b0, 2'd2);
    @(negedge clk);
    outs("t1.after", 2'b00, 1'b0, 2'd2);

    // 2: second pattern, leading extra digit
    cfg(1'b1, pk(0, 6, 1, 9), 1'b1);
    press(4'hF);
    outs("t2.clr", 2'b00, 1'b0, 2'd0);
    press(4'h7);
    outs("t2.k7", 2'b00, 1'b0, 2'd1);
    press(4'h0);
    press(4'h6);
    press(4'h1);
    outs("t2.k1", 2'b00, 1'b0, 2'd2);
    press(4'h9);
    outs("t2.k9", 2'b10, 1'b1, 2'd2);
    @(negedge clk);
    outs("t2.after", 2'b00, 1'b1, 2'd2);

    // 3: clear key mid-entry
    press(4'hF);
    press(4'h0);
    press(4'h5);
    press(4'hF);
    outs("t3.clr", 2'b00, 1'b1, 2'd0);
    press(4'h3);
    press(4'h1);
    outs("t3.k31", 2'b00, 1'b1, 2'd1);
    press(4'h0);
    press(4'h5);
    outs("t3.k05", 2'b00, 1'b1, 2'd2);
    press(4'h3);
    press(4'h1);
    outs("t3.hit", 2'b01, 1'b0, 2'd2);

    // 4: both patterns identical
    cfg(1'b0, pk(2, 2, 2, 2), 1'b1);
    cfg(1'b1, pk(2, 2, 2, 2), 1'b1);
    press(4'hF);
    press(4'h2);
    press(4'h2);
    press(4'h2);
    outs("t4.k3", 2'b00, 1'b0, 2'd1);
    press(4'h2);
    outs("t4.k4", 2'b11, 1'b0, 2'd2);
    press(4'h2);
    outs("t4.k5", 2'b11, 1'b0, 2'd2);

    // 5: disable written with the final key
    cfg(1'b0, pk(0, 5, 3, 1), 1'b1);
    press(4'hF);
    press(4'h0);
    press(4'h5);
    press(4'h3);
    cfg_we    = 1'b1;
    cfg_idx   = 1'b0;
    cfg_pat   = pk(0, 5, 3, 1);
    cfg_en    = 1'b0;
    key_valid = 1'b1;
    din       = 4'h1;
    @(negedge clk);
    cfg_we    = 1'b0;
    key_valid = 1'b0;
    outs("t5.old", 2'b01, 1'b0, 2'd2);
    press(4'h0);
    press(4'h5);
    press(4'h3);
    press(4'h1);
    outs("t5.dis", 2'b00, 1'b0, 2'd2);

    // 6: idle behaviour, then async reset mid-entry
    press(4'hF);
    press(4'h0);
    press(4'h5);
`ifdef KPD_TIMEOUT_EN
    repeat (7) @(negedge clk);
    check("t6.pre", 32'(timeout), 32'd0);
    press(4'h3);
    check("t6.key8.to", 32'(timeout), 32'd0);
    check("t6.key8.st", 32'(fsm_state), 32'd1);
    repeat (7) @(negedge clk);
    check("t6.seven", 32'(timeout), 32'd0);
    @(negedge clk);
    check("t6.to", 32'(timeout), 32'd1);
    check("t6.to.st", 32'(fsm_state), 32'd0);
    @(negedge clk);
    check("t6.pulse", 32'(timeout), 32'd0);
`else
    begin
      logic seen;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (timeout) seen = 1'b1;
      end
      check("t6.noto", 32'(seen), 32'd0);
      check("t6.kept", 32'(fsm_state), 32'd1);
    end
`endif
    cfg(1'b0, pk(0, 5, 3, 1), 1'b1);
    press(4'hF);
    press(4'h0);
    press(4'h5);
    press(4'h3);
    press(4'h1);
    outs("t6.prerst", 2'b01, 1'b0, 2'd2);
    #1 reset_n = 1'b0;
    #1;
    outs("t6.rst", 2'b00, 1'b0, 2'd0);
    check("t6.rst.to", 32'(timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    press(4'h0);
    press(4'h5);
    press(4'h3);
    press(4'h1);
    outs("t6.cleared", 2'b00, 1'b0, 2'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
